alu_nibble_sequencer: RTL and testbench
=======================================

// Module: alu_nibble_sequencer
// PURPOSE
//  Multi-cycle controller that runs a WIDTH-bit operation through the shared 4-bit ripple ALU slice one nibble per cycle.
//  It owns the ALU's a/b/c/aluctr inputs, registers the carry between nibbles, and assembles d[3:0] into a WIDTH-bit result.
//  It sits between a requester (start/done handshake) and a single 4-bit ALU instance.
//  It does not depend on the opcode: aluctr is passed through unchanged and the carry chain is always honoured.
// PARAMETERS
//  WIDTH  16  operand/result width; multiple of 4, >=4; NIB = WIDTH/4 ALU passes
// PORTS
//  clk      in   1      single clock, rising edge
//  rst      in   1      synchronous, active-high reset
//  start    in   1      request; accepted only in IDLE
//  a        in   WIDTH  operand A, sampled on accepted start
//  b        in   WIDTH  operand B, sampled on accepted start
//  c        in   1      carry-in to nibble 0, sampled on accepted start
//  aluctr   in   2      ALU op select, sampled on accepted start
//  busy     out  1      high in RUN and DONE
//  done     out  1      one-cycle pulse; result/e valid
//  d        out  WIDTH  assembled result, held until the next accepted start
//  e        out  1      final carry-out (carry from nibble NIB-1)
//  alu_a    out  4      to ALU a
//  alu_b    out  4      to ALU b
//  alu_c    out  1      to ALU c
//  alu_ctr  out  2      to ALU aluctr
//  alu_d    in   4      from ALU d, combinational same cycle
//  alu_e    in   1      from ALU e, combinational same cycle
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE; idx=0; busy=0, done=0, d=0, e=0, carry reg=0, latched operands=0.
//  - FSM states:
//    - IDLE: start=1 -> latch a, b, c, aluctr; idx<=0; go to RUN.
//    - RUN: each cycle, process nibble idx:
//      - Drive alu_a=A[4*idx+:4], alu_b=B[4*idx+:4], alu_c=carry reg, alu_ctr=latched ctr.
//      - At the posedge: d[4*idx+:4]<=alu_d, carry<=alu_e.
//      - idx==NIB-1 -> e<=alu_e, go to DONE; otherwise idx<=idx+1.
//    - DONE: done=1 for exactly this one cycle; next state is IDLE.
//  - ALU-facing outputs are combinational from registers. In IDLE and DONE they are all 0.
//  - Latency: start accepted at edge T; RUN occupies edges T+1..T+NIB; done is high in the cycle after edge T+NIB.
//    - WIDTH=16: done is high 5 cycles after start is sampled.
//  - start while busy=1: ignored, no effect on the operation in flight. Operand changes after acceptance are also ignored.
//  - start held high continuously: the next operation is accepted in the IDLE cycle after DONE; back-to-back period is NIB+2 cycles.
//  - d is not cleared on start: nibbles are overwritten in order and only the full value at done is defined.
//  - idx width: $clog2(NIB), minimum 1 bit. With WIDTH=4, RUN lasts one cycle.
//  - rst during RUN/DONE: aborts immediately to the reset state. No done pulse is produced.
// CONFIGURATION
//  - ALU_SEQ_ZFLAG_EN defined:
//    - Adds output z (1 bit): 1 when the complete assembled d == 0.
//    - Registered at the same edge as e; valid while done=1; holds until next start; reset 0.
//  - Not defined: port z is absent and no zero-detect logic exists.
// TESTING (bench drives alu_d/alu_e from a behavioural model {e,d}=a+b+c; it also checks that alu_ctr mirrors latched aluctr)
//  1. WIDTH=16: a=16'h1234, b=16'h1111, c=0, aluctr=2'b10
//     -> done 5 cycles after start; d=16'h2345, e=0; alu_ctr=2'b10 during RUN.
//  2. Carry ripple: a=16'hFFFF, b=16'h0000, c=1
//     -> alu_c per RUN cycle = 1,1,1,1; d=16'h0000, e=1; z=1 if ALU_SEQ_ZFLAG_EN.
//  3. Busy lockout: start with a=16'h0001,b=16'h0001; pulse start with a=16'hFFFF at RUN cycle 2
//     -> single done, d=16'h0002; the second start is never accepted.
//  4. Continuous start=1 with a=16'h0F0F,b=16'h00F1,c=0
//     -> done pulses every 6 cycles, d=16'h1000 each time.
//  5. rst asserted in RUN cycle 3
//     -> next cycle: busy=0, done=0, d=0, e=0, alu_* = 0; no done pulse. A fresh start then completes normally.
//  6. WIDTH=4: a=4'h9,b=4'h8,c=0
//     -> one RUN cycle; done 2 cycles after start; d=4'h1, e=1.

Source files
------------

// File: rtl/alu_nibble_sequencer.sv
// Nibble-serial controller that drives a shared 4-bit ALU slice and assembles a WIDTH-bit result.
// Optional zero flag output z is enabled by defining ALU_SEQ_ZFLAG_EN.
module alu_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic [1:0]       aluctr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             e,
`ifdef ALU_SEQ_ZFLAG_EN
  output logic             z,
`endif
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic             alu_c,
  output logic [1:0]       alu_ctr,
  input  logic [3:0]       alu_d,
  input  logic             alu_e
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_r;
  logic [IDXW-1:0]  idx_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [1:0]       ctr_r;

  logic [IDXW+1:0]  shamt_s;
  logic             last_s;
  logic [WIDTH-1:0] d_next_s;

  // Nibble selection, result merge and ALU-facing drive (zero outside RUN)
  always_comb begin
    shamt_s  = {idx_r, 2'b00};
    last_s   = (idx_r == IDXW'(NIB - 1));
    d_next_s = (d & ~(WIDTH'(4'hF) << shamt_s)) | (WIDTH'(alu_d) << shamt_s);
    alu_a    = 4'h0;
    alu_b    = 4'h0;
    alu_c    = 1'b0;
    alu_ctr  = 2'b00;
    if (state_r == ST_RUN) begin
      alu_a   = 4'(a_r >> shamt_s);
      alu_b   = 4'(b_r >> shamt_s);
      alu_c   = carry_r;
      alu_ctr = ctr_r;
    end else begin
      alu_a   = 4'h0;
      alu_b   = 4'h0;
      alu_c   = 1'b0;
      alu_ctr = 2'b00;
    end
  end

  // Sequencer state, operand latches, carry chain and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= {IDXW{1'b0}};
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      ctr_r   <= 2'b00;
      busy    <= 1'b0;
      done    <= 1'b0;
      d       <= {WIDTH{1'b0}};
      e       <= 1'b0;
`ifdef ALU_SEQ_ZFLAG_EN
      z       <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= c;
            ctr_r   <= aluctr;
            idx_r   <= {IDXW{1'b0}};
            busy    <= 1'b1;
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          d       <= d_next_s;
          carry_r <= alu_e;
          if (last_s) begin
            e       <= alu_e;
`ifdef ALU_SEQ_ZFLAG_EN
            z       <= (d_next_s == {WIDTH{1'b0}});
`endif
            done    <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            idx_r <= idx_r + IDXW'(1);
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Self-checking bench: WIDTH=16 and WIDTH=4 sequencers, each driving a behavioural adder ALU.
// Honours ALU_SEQ_ZFLAG_EN when defined.
module tb_alu_nibble_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        c;
  logic [1:0]  aluctr;
  logic        busy, done, e;
  logic [15:0] d;
  logic [3:0]  alu_a, alu_b, alu_d;
  logic        alu_c, alu_e;
  logic [1:0]  alu_ctr;

  logic        start4;
  logic [3:0]  a4, b4, d4;
  logic        c4, busy4, done4, e4;
  logic [3:0]  alu_a4, alu_b4, alu_d4;
  logic        alu_c4, alu_e4;
  logic [1:0]  alu_ctr4;
`ifdef ALU_SEQ_ZFLAG_EN
  logic        z, z4;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Behavioural ALU slices: plain nibble adders
  assign {alu_e, alu_d}   = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0000, alu_c};
  assign {alu_e4, alu_d4} = {1'b0, alu_a4} + {1'b0, alu_b4} + {4'b0000, alu_c4};

  alu_nibble_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c), .aluctr(aluctr),
    .busy(busy), .done(done), .d(d), .e(e),
`ifdef ALU_SEQ_ZFLAG_EN
    .z(z),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_ctr(alu_ctr),
    .alu_d(alu_d), .alu_e(alu_e)
  );

  alu_nibble_sequencer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .c(c4), .aluctr(2'b01),
    .busy(busy4), .done(done4), .d(d4), .e(e4),
`ifdef ALU_SEQ_ZFLAG_EN
    .z(z4),
`endif
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_c(alu_c4), .alu_ctr(alu_ctr4),
    .alu_d(alu_d4), .alu_e(alu_e4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present an operation, then return at the sample point of the first RUN cycle with operands scrambled
  task automatic start_op(input logic [15:0] oa, input logic [15:0] ob, input logic oc, input logic [1:0] octr);
    @(negedge clk);
    a = oa; b = ob; c = oc; aluctr = octr; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); c = 1'($urandom); aluctr = 2'($urandom);
  endtask

  // Follow the operation to done, checking each nibble pass and the final result; poke>=0 re-pulses start
  task automatic wait_done(input logic [15:0] oa, input logic [15:0] ob, input logic oc,
                           input logic [1:0] octr, input int poke);
    logic [16:0] sum;
    int unsigned m, lowsum, cin;
    int k;
    bit seen;
    sum  = {1'b0, oa} + {1'b0, ob} + {16'h0000, oc};
    k    = 0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        m      = 32'd1 << (4 * k);
        lowsum = (32'(oa) % m) + (32'(ob) % m) + 32'(oc);
        cin    = lowsum >> (4 * k);
        check_eq("busy_run", 32'(busy), 32'd1);
        check_eq("alu_a", 32'(alu_a), (32'(oa) >> (4 * k)) & 32'hF);
        check_eq("alu_b", 32'(alu_b), (32'(ob) >> (4 * k)) & 32'hF);
        check_eq("alu_c", 32'(alu_c), cin);
        check_eq("alu_ctr", 32'(alu_ctr), 32'(octr));
        if (k == poke) begin
          a = 16'hFFFF; start = 1'b1;
        end else begin
          start = 1'b0;
        end
        k++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    check_eq("done_seen", 32'(seen), 32'd1);
    check_eq("run_cycles", 32'(k), 32'd4);
    check_eq("d", 32'(d), 32'(sum[15:0]));
    check_eq("e", 32'(e), 32'(sum[16]));
`ifdef ALU_SEQ_ZFLAG_EN
    check_eq("z", 32'(z), 32'(sum[15:0] == 16'h0000));
`endif
    @(negedge clk);
    check_eq("done_width", 32'(done), 32'd0);
    check_eq("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rc;
    logic [1:0]  rctr;
    logic [4:0]  s4;
    int last, npulse, poke;
    bit seen;

    rst = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0; c = 1'b0; aluctr = 2'b00;
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; c4 = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_d", 32'(d), 32'd0);
    check_eq("rst_e", 32'(e), 32'd0);
    check_eq("rst_alu", {19'd0, alu_a, alu_b, alu_c, alu_ctr}, 32'd0);
    rst = 1'b0;

    // Directed: plain add, carry ripple, busy lockout
    start_op(16'h1234, 16'h1111, 1'b0, 2'b10);
    wait_done(16'h1234, 16'h1111, 1'b0, 2'b10, -1);
    start_op(16'hFFFF, 16'h0000, 1'b1, 2'b00);
    wait_done(16'hFFFF, 16'h0000, 1'b1, 2'b00, -1);
    start_op(16'h0001, 16'h0001, 1'b0, 2'b01);
    wait_done(16'h0001, 16'h0001, 1'b0, 2'b01, 2);
    @(negedge clk);
    check_eq("lockout_idle", 32'(busy), 32'd0);

    // Continuous start: one result every 6 cycles
    @(negedge clk);
    a = 16'h0F0F; b = 16'h00F1; c = 1'b0; aluctr = 2'b11; start = 1'b1;
    last = -1; npulse = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done) begin
        check_eq("cont_d", 32'(d), 32'h1000);
        if (last >= 0) check_eq("cont_period", 32'(cyc - last), 32'd6);
        else check_eq("cont_first", 32'(cyc), 32'd4);
        last = cyc;
        npulse++;
      end
    end
    start = 1'b0;
    check_eq("cont_pulses", 32'(npulse), 32'd6);
    for (int i = 0; i < 20 && (busy || done); i++) @(negedge clk);
    check_eq("cont_drain", 32'(busy), 32'd0);

    // Abort in RUN via reset, after leaving d and e non-zero
    start_op(16'hFFFF, 16'h0002, 1'b0, 2'b00);
    wait_done(16'hFFFF, 16'h0002, 1'b0, 2'b00, -1);
    start_op(16'h5555, 16'h2222, 1'b1, 2'b10);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_d", 32'(d), 32'd0);
    check_eq("abort_e", 32'(e), 32'd0);
    check_eq("abort_alu", {19'd0, alu_a, alu_b, alu_c, alu_ctr}, 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check_eq("abort_no_done", 32'(seen), 32'd0);
    start_op(16'h8001, 16'h7FFF, 1'b0, 2'b01);
    wait_done(16'h8001, 16'h7FFF, 1'b0, 2'b01, -1);

    // Random operations with occasional start pulses while busy
    for (int i = 0; i < 25; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rctr = 2'($urandom);
      if (i % 5 == 0) rb = ~ra;
      poke = int'($urandom_range(0, 4)) - 1;
      start_op(ra, rb, rc, rctr);
      wait_done(ra, rb, rc, rctr, poke);
    end

    // WIDTH=4: single RUN cycle
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        a4 = 4'h9; b4 = 4'h8; c4 = 1'b0;
      end else begin
        a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
      end
      s4 = {1'b0, a4} + {1'b0, b4} + {4'h0, c4};
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      check_eq("w4_busy", 32'(busy4), 32'd1);
      check_eq("w4_run_done", 32'(done4), 32'd0);
      check_eq("w4_alu_a", 32'(alu_a4), 32'(a4));
      check_eq("w4_alu_c", 32'(alu_c4), 32'(c4));
      @(negedge clk);
      check_eq("w4_done", 32'(done4), 32'd1);
      check_eq("w4_d", 32'(d4), 32'(s4[3:0]));
      check_eq("w4_e", 32'(e4), 32'(s4[4]));
`ifdef ALU_SEQ_ZFLAG_EN
      check_eq("w4_z", 32'(z4), 32'(s4[3:0] == 4'h0));
`endif
      @(negedge clk);
      check_eq("w4_idle", 32'(busy4 | done4), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
